// File: rtl/mdu_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Holds the op and state encodings plus the per-operation iteration count.
package mdu_pkg;

    localparam int ITER_N = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [2:0] {
        OP_MULTU = 3'd0,
        OP_MULT  = 3'd1,
        OP_DIVU  = 3'd2,
        OP_DIV   = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [2:0] o);
        return (o == OP_MULTU) || (o == OP_MULT) || (o == OP_DIVU) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Sign handling for mdu_seq: operand magnitudes on entry, result sign correction on exit.
// Latency: purely combinational. Backpressure: none.
// Divide corrects quotient and remainder independently; multiply negates the full 64-bit product.
module mdu_signfix
    import mdu_pkg::*;
(
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        sgn_op,
    output logic [31:0] a_mag,
    output logic [31:0] b_mag,
    output logic        a_neg,
    output logic        b_neg,
    input  logic [63:0] acc_in,
    input  logic        is_div,
    input  logic        neg_lo,
    input  logic        neg_hi,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        a_neg = sgn_op & a_in[31];
        b_neg = sgn_op & b_in[31];
        a_mag = a_neg ? (~a_in + 32'd1) : a_in;
        b_mag = b_neg ? (~b_in + 32'd1) : b_in;

        prod = neg_lo ? (~acc_in + 64'd1) : acc_in;
        quot = neg_lo ? (~acc_in[31:0] + 32'd1) : acc_in[31:0];
        rem  = neg_hi ? (~acc_in[63:32] + 32'd1) : acc_in[63:32];

        hi_out = is_div ? rem  : prod[63:32];
        lo_out = is_div ? quot : prod[31:0];
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MIPS-style HI/LO multiply/divide unit with MTHI/MTLO moves.
// Latency: 33 cycles busy per MULT/DIV, results and done one cycle after; moves write next edge.
// Backpressure: start is only sampled in IDLE; busy tells the pipeline to stall otherwise.
module mdu_seq
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        acc_q, acc_d;
    logic [31:0]        opd_q, opd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               done_q, done_d;

    logic               sgn_op;
    logic [31:0]        a_mag, b_mag;
    logic               a_neg, b_neg;
    logic [31:0]        fix_hi, fix_lo;

    logic [32:0]        mul_sum;
    logic [63:0]        mul_step;
    logic [33:0]        div_diff;
    logic [63:0]        div_step;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

    assign sgn_op = (op == OP_MULT) || (op == OP_DIV);

    mdu_signfix u_signfix (
        .a_in   (a),
        .b_in   (b),
        .sgn_op (sgn_op),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .a_neg  (a_neg),
        .b_neg  (b_neg),
        .acc_in (acc_q),
        .is_div (is_div_q),
        .neg_lo (neg_lo_q),
        .neg_hi (neg_hi_q),
        .hi_out (fix_hi),
        .lo_out (fix_lo)
    );

    // Multiply: acc = {partial, multiplier}; add multiplicand on the LSB, shift right.
    // Divide: acc = {remainder, dividend}; shift left, trial-subtract the divisor.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
        mul_step = {mul_sum, acc_q[31:1]};
        div_diff = {1'b0, acc_q[63:31]} - {2'b00, opd_q};
        if (!div_diff[33]) begin
            div_step = {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            div_step = {acc_q[62:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_iter_op(op)) begin
                        acc_d    = {32'd0, a_mag};
                        opd_d    = b_mag;
                        is_div_d = (op == OP_DIVU) || (op == OP_DIV);
                        // Zero divisor keeps the raw all-ones quotient; remainder follows the dividend.
                        neg_lo_d = (a_neg ^ b_neg) & (b != 32'd0);
                        neg_hi_d = a_neg;
                        cnt_d    = '0;
                        state_d  = ST_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: driver pushes expected {hi,lo}, monitor pops on done.
module tb_mdu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sb_q[$];
    logic [31:0] m_hi, m_lo;

    mdu_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ux, uy;
        longint      sx, sy, q, r;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            3'd0: return ux * uy;
            3'd1: return 64'(sx * sy);
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns 1 ns after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit track);
        logic [63:0] r;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (track) begin
            if (o <= 3'd3) begin
                r = model(o, x, y);
                sb_q.push_back(r);
                m_hi = r[63:32];
                m_lo = r[31:0];
            end else if (o == 3'd4) begin
                m_hi = x;
            end else if (o == 3'd5) begin
                m_lo = x;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    // Monitor: scoreboard pop on done, busy length, done width, hi/lo hold while busy.
    initial begin
        int          run_len;
        logic        prev_busy, prev_done;
        logic [31:0] prev_hi, prev_lo;
        logic [63:0] e;
        run_len   = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        prev_hi   = '0;
        prev_lo   = '0;
        forever begin
            @(negedge clk);
            if (busy && prev_busy) begin
                chk("hold_hi", 64'(hi), 64'(prev_hi));
                chk("hold_lo", 64'(lo), 64'(prev_lo));
            end
            if (busy) begin
                run_len++;
            end else begin
                if (done) begin
                    chk("busy_len", 64'(run_len), 64'd33);
                    chk("done_width", 64'(prev_done), 64'd0);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("result_hi", 64'(hi), 64'(e[63:32]));
                        chk("result_lo", 64'(lo), 64'(e[31:0]));
                    end
                end
                run_len = 0;
            end
            prev_busy = busy;
            prev_done = done;
            prev_hi   = hi;
            prev_lo   = lo;
        end
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y, old_lo;
        bit          any;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        m_hi  = '0;
        m_lo  = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed corner ops, each issued in the previous op's done cycle.
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_done();
        issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1);          wait_done();
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1);          wait_done();
        issue(3'd2, 32'd100, 32'd0, 1);                wait_done();
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1);  wait_done();
        issue(3'd3, 32'hFFFF_FFFB, 32'd0, 1);          wait_done();
        @(negedge clk);

        issue(3'd4, 32'h0000_1234, 32'd0, 1);
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        @(negedge clk);
        issue(3'd5, 32'h0BAD_F00D, 32'd0, 1);
        chk("mtlo_lo", 64'(lo), 64'h0BAD_F00D);
        @(negedge clk);

        issue(3'd6, 32'h5555_5555, 32'd1, 1);
        chk("rsvd_hi", 64'(hi), 64'(m_hi));
        chk("rsvd_lo", 64'(lo), 64'(m_lo));
        chk("rsvd_busy", 64'(busy), 64'd0);
        @(negedge clk);

        // MTLO while busy must be dropped.
        old_lo = m_lo;
        issue(3'd0, 32'd3, 32'd5, 1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        a     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_mtlo_lo", 64'(lo), 64'(old_lo));
        chk("busy_mtlo_busy", 64'(busy), 64'd1);
        wait_done();
        @(negedge clk);

        // Abort DIVU 50/7 ten cycles into RUN.
        issue(3'd2, 32'd50, 32'd7, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        any = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) any = 1'b1;
        end
        chk("abort_no_done", 64'(any), 64'd0);

        issue(3'd1, $urandom, $urandom, 1); wait_done();
        issue(3'd2, 32'd50, 32'd7, 1);      wait_done();

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            issue(o, x, y, 1);
            if (o <= 3'd3) begin
                wait_done();
            end else begin
                chk("idle_hi", 64'(hi), 64'(m_hi));
                chk("idle_lo", 64'(lo), 64'(m_lo));
                chk("idle_busy", 64'(busy), 64'd0);
                @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
